// File: rtl/idu_pkg.sv
// Shared types and constants for the instruction-decode stage.
package idu_pkg;

  typedef enum logic [4:0] {
    ALU_ADD    = 5'd0,
    ALU_SUB    = 5'd1,
    ALU_SLL    = 5'd2,
    ALU_SLT    = 5'd3,
    ALU_SLTU   = 5'd4,
    ALU_XOR    = 5'd5,
    ALU_SRL    = 5'd6,
    ALU_SRA    = 5'd7,
    ALU_OR     = 5'd8,
    ALU_AND    = 5'd9,
    ALU_BEQ    = 5'd10,
    ALU_BNE    = 5'd11,
    ALU_BLT    = 5'd12,
    ALU_BGE    = 5'd13,
    ALU_BLTU   = 5'd14,
    ALU_BGEU   = 5'd15,
    ALU_MUL    = 5'd16,
    ALU_MULH   = 5'd17,
    ALU_MULHSU = 5'd18,
    ALU_MULHU  = 5'd19,
    ALU_DIV    = 5'd20,
    ALU_DIVU   = 5'd21,
    ALU_REM    = 5'd22,
    ALU_REMU   = 5'd23
  } alu_op_t;

  typedef enum logic [1:0] {
    CSR_NONE = 2'd0,
    CSR_RW   = 2'd1,
    CSR_SET  = 2'd2,
    CSR_CLR  = 2'd3
  } csr_op_t;

  // A CSR access without a write shares the NONE code; EXU still sees
  // reg_write and the CSR address in imm.
  localparam csr_op_t CSR_READ = CSR_NONE;

  // Occupancy of the main/skid storage pair.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Bit positions inside the 10-bit control vector.
  localparam int unsigned CTRL_MEM_READ  = 9;
  localparam int unsigned CTRL_MEM_WRITE = 8;
  localparam int unsigned CTRL_REG_WRITE = 7;
  localparam int unsigned CTRL_ALU_SRC   = 6;
  localparam int unsigned CTRL_MEM_TO_REG = 5;
  localparam int unsigned CTRL_BRANCH    = 4;
  localparam int unsigned CTRL_JAL       = 3;
  localparam int unsigned CTRL_JALR      = 2;
  localparam int unsigned CTRL_AUIPC     = 1;
  localparam int unsigned CTRL_LUI       = 0;

  // Register fields are carried at full 5-bit width; the stage narrows them.
  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    alu_op_t     alu_op;
    logic [9:0]  ctrl;
    logic [2:0]  funct3;
    csr_op_t     csr_op;
    logic        csr_uimm;
    logic [1:0]  sys;
    logic        illegal;
  } dec_t;

  typedef struct packed {
    logic [31:0] pc;
    dec_t        dec;
  } entry_t;

  // True when a used register field addresses beyond the register file.
  function automatic logic reg_oob(input logic [4:0] r, input int unsigned w);
    return (w < 32'd5) && r[4];
  endfunction

endpackage

// File: rtl/idu_decode.sv
// Purely combinational RV32E/RV32I (+M, +Zicsr) instruction decoder.
module idu_decode
  import idu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter bit          EN_M       = 1'b0,
  parameter bit          EN_ZICSR   = 1'b1
) (
  input  logic [31:0] inst,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [4:0]  rd_f;
  logic [2:0]  f3;
  logic [4:0]  rs1_f;
  logic [4:0]  rs2_f;
  logic [6:0]  f7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_u;
  logic [31:0] imm_j;

  assign opcode = inst[6:0];
  assign rd_f   = inst[11:7];
  assign f3     = inst[14:12];
  assign rs1_f  = inst[19:15];
  assign rs2_f  = inst[24:20];
  assign f7     = inst[31:25];
  assign imm_i  = {{20{inst[31]}}, inst[31:20]};
  assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
  assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  assign imm_u  = {inst[31:12], 12'b0};
  assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

  function automatic alu_op_t alu_from_f3(input logic [2:0] f);
    case (f)
      3'b000:  return ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  logic ill;
  logic chk_rs1;
  logic chk_rs2;
  logic chk_rd;

  // Opcode decode; an illegal result collapses the bundle to just the flag.
  always_comb begin
    dec     = '0;
    ill     = 1'b0;
    chk_rs1 = 1'b0;
    chk_rs2 = 1'b0;
    chk_rd  = 1'b0;
    dec.funct3 = f3;
    case (opcode)
      OP_LUI: begin
        dec.rd  = rd_f;
        chk_rd  = 1'b1;
        dec.imm = imm_u;
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]   = 1'b1;
        dec.ctrl[CTRL_LUI]       = 1'b1;
      end
      OP_AUIPC: begin
        dec.rd  = rd_f;
        chk_rd  = 1'b1;
        dec.imm = imm_u;
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]   = 1'b1;
        dec.ctrl[CTRL_AUIPC]     = 1'b1;
      end
      OP_JAL: begin
        dec.rd  = rd_f;
        chk_rd  = 1'b1;
        dec.imm = imm_j;
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        dec.ctrl[CTRL_JAL]       = 1'b1;
      end
      OP_JALR: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        chk_rd  = 1'b1;
        chk_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]   = 1'b1;
        dec.ctrl[CTRL_JALR]      = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
      end
      OP_BRANCH: begin
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        chk_rs1 = 1'b1;
        chk_rs2 = 1'b1;
        dec.imm = imm_b;
        dec.ctrl[CTRL_BRANCH] = 1'b1;
        case (f3)
          3'b000:  dec.alu_op = ALU_BEQ;
          3'b001:  dec.alu_op = ALU_BNE;
          3'b100:  dec.alu_op = ALU_BLT;
          3'b101:  dec.alu_op = ALU_BGE;
          3'b110:  dec.alu_op = ALU_BLTU;
          3'b111:  dec.alu_op = ALU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OP_LOAD: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        chk_rd  = 1'b1;
        chk_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.ctrl[CTRL_MEM_READ]   = 1'b1;
        dec.ctrl[CTRL_REG_WRITE]  = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]    = 1'b1;
        dec.ctrl[CTRL_MEM_TO_REG] = 1'b1;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) ill = 1'b1;
      end
      OP_STORE: begin
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        chk_rs1 = 1'b1;
        chk_rs2 = 1'b1;
        dec.imm = imm_s;
        dec.ctrl[CTRL_MEM_WRITE] = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]   = 1'b1;
        if (f3[2] || f3 == 3'b011) ill = 1'b1;
      end
      OP_IMM: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        chk_rd  = 1'b1;
        chk_rs1 = 1'b1;
        dec.imm = imm_i;
        dec.alu_op = alu_from_f3(f3);
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        dec.ctrl[CTRL_ALU_SRC]   = 1'b1;
        if (f3 == 3'b001) begin
          dec.imm = {27'b0, inst[24:20]};
          if (f7 != 7'h00) ill = 1'b1;
        end else if (f3 == 3'b101) begin
          dec.imm    = {27'b0, inst[24:20]};
          dec.alu_op = inst[30] ? ALU_SRA : ALU_SRL;
          if (inst[31] || inst[29:25] != 5'b0) ill = 1'b1;
        end
      end
      OP_REG: begin
        dec.rd  = rd_f;
        dec.rs1 = rs1_f;
        dec.rs2 = rs2_f;
        chk_rd  = 1'b1;
        chk_rs1 = 1'b1;
        chk_rs2 = 1'b1;
        dec.ctrl[CTRL_REG_WRITE] = 1'b1;
        case (f7)
          7'h00: dec.alu_op = alu_from_f3(f3);
          7'h20: begin
            if (f3 == 3'b000)      dec.alu_op = ALU_SUB;
            else if (f3 == 3'b101) dec.alu_op = ALU_SRA;
            else                   ill = 1'b1;
          end
          7'h01: begin
            if (EN_M) dec.alu_op = alu_op_t'({2'b10, f3});
            else      ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        if (f3 == 3'b000) begin
          if (inst[31:20] == 12'h000)      dec.sys = 2'b10;
          else if (inst[31:20] == 12'h001) dec.sys = 2'b01;
          else                             ill = 1'b1;
        end else if (EN_ZICSR && f3 != 3'b100) begin
          dec.rd       = rd_f;
          dec.rs1      = rs1_f;
          chk_rd       = 1'b1;
          chk_rs1      = !f3[2];
          dec.imm      = {20'b0, inst[31:20]};
          dec.csr_uimm = f3[2];
          dec.ctrl[CTRL_REG_WRITE] = 1'b1;
          case (f3[1:0])
            2'b01:   dec.csr_op = CSR_RW;
            2'b10:   dec.csr_op = (rs1_f == 5'd0) ? CSR_READ : CSR_SET;
            default: dec.csr_op = (rs1_f == 5'd0) ? CSR_READ : CSR_CLR;
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    if ((chk_rs1 && reg_oob(rs1_f, REG_ADDR_W)) ||
        (chk_rs2 && reg_oob(rs2_f, REG_ADDR_W)) ||
        (chk_rd  && reg_oob(rd_f,  REG_ADDR_W))) begin
      ill = 1'b1;
    end
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/idu_stage.sv
// Registered decode stage: decoder feeding a main + skid entry buffer.
module idu_stage
  import idu_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 4,
  parameter bit          EN_M       = 1'b0,
  parameter bit          EN_ZICSR   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           in_inst,
  input  logic [31:0]           in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [31:0]           out_pc,
  output logic [REG_ADDR_W-1:0] out_rs1,
  output logic [REG_ADDR_W-1:0] out_rs2,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [31:0]           out_imm,
  output logic [4:0]            out_alu_op,
  output logic [9:0]            out_ctrl,
  output logic [2:0]            out_funct3,
  output logic [1:0]            out_csr_op,
  output logic                  out_csr_uimm,
  output logic [1:0]            out_sys,
  output logic                  out_illegal
);

  dec_t   dec_new;
  entry_t new_entry;
  entry_t main_q;
  entry_t skid_q;
  occ_t   occ_q;
  occ_t   occ_d;
  logic   accept;
  logic   drain;
  logic   load_main_new;
  logic   load_main_skid;
  logic   load_skid;

  idu_decode #(
    .REG_ADDR_W (REG_ADDR_W),
    .EN_M       (EN_M),
    .EN_ZICSR   (EN_ZICSR)
  ) u_decode (
    .inst (in_inst),
    .dec  (dec_new)
  );

  assign new_entry = {in_pc, dec_new};

  // Both handshake outputs come straight from the occupancy register.
  assign in_ready  = (occ_q != OCC_TWO);
  assign out_valid = (occ_q != OCC_EMPTY);
  assign accept    = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;

  // Occupancy next-state and data-move selects; flush wins over everything.
  always_comb begin
    occ_d          = occ_q;
    load_main_new  = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      occ_d = OCC_EMPTY;
    end else begin
      case (occ_q)
        OCC_EMPTY: begin
          if (accept) begin
            occ_d         = OCC_ONE;
            load_main_new = 1'b1;
          end
        end
        OCC_ONE: begin
          if (accept && drain) begin
            load_main_new = 1'b1;
          end else if (accept) begin
            occ_d     = OCC_TWO;
            load_skid = 1'b1;
          end else if (drain) begin
            occ_d = OCC_EMPTY;
          end
        end
        OCC_TWO: begin
          if (drain) begin
            occ_d          = OCC_ONE;
            load_main_skid = 1'b1;
          end
        end
        default: occ_d = OCC_EMPTY;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) occ_q <= OCC_EMPTY;
    else        occ_q <= occ_d;
  end

  // Entry payload registers; cleared on reset and flush so idle outputs read 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main_new)       main_q <= new_entry;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid)           skid_q <= new_entry;
    end
  end

  // With a 16-entry file the decoder guarantees bit 4 is zero on legal ops.
  logic unused_reg_msb;
  assign unused_reg_msb = ^{main_q.dec.rs1, main_q.dec.rs2, main_q.dec.rd};

  assign out_pc       = main_q.pc;
  assign out_rs1      = main_q.dec.rs1[REG_ADDR_W-1:0];
  assign out_rs2      = main_q.dec.rs2[REG_ADDR_W-1:0];
  assign out_rd       = main_q.dec.rd[REG_ADDR_W-1:0];
  assign out_imm      = main_q.dec.imm;
  assign out_alu_op   = main_q.dec.alu_op;
  assign out_ctrl     = main_q.dec.ctrl;
  assign out_funct3   = main_q.dec.funct3;
  assign out_csr_op   = main_q.dec.csr_op;
  assign out_csr_uimm = main_q.dec.csr_uimm;
  assign out_sys      = main_q.dec.sys;
  assign out_illegal  = main_q.dec.illegal;

endmodule

// File: tb/tb_idu_stage.sv
// Directed, table-driven bench for idu_stage (RV32E/no-M and RV32I/M builds).
module tb_idu_stage;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [3:0]  out_rs1;
  logic [3:0]  out_rs2;
  logic [3:0]  out_rd;
  logic [31:0] out_imm;
  logic [4:0]  out_alu_op;
  logic [9:0]  out_ctrl;
  logic [2:0]  out_funct3;
  logic [1:0]  out_csr_op;
  logic        out_csr_uimm;
  logic [1:0]  out_sys;
  logic        out_illegal;

  logic        x_in_ready;
  logic        x_out_valid;
  logic [31:0] x_out_pc;
  logic [4:0]  x_out_rs1;
  logic [4:0]  x_out_rs2;
  logic [4:0]  x_out_rd;
  logic [31:0] x_out_imm;
  logic [4:0]  x_out_alu_op;
  logic [9:0]  x_out_ctrl;
  logic [2:0]  x_out_funct3;
  logic [1:0]  x_out_csr_op;
  logic        x_out_csr_uimm;
  logic [1:0]  x_out_sys;
  logic        x_out_illegal;

  idu_stage #(.REG_ADDR_W(4), .EN_M(1'b0), .EN_ZICSR(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_ctrl(out_ctrl), .out_funct3(out_funct3),
    .out_csr_op(out_csr_op), .out_csr_uimm(out_csr_uimm), .out_sys(out_sys),
    .out_illegal(out_illegal)
  );

  idu_stage #(.REG_ADDR_W(5), .EN_M(1'b1), .EN_ZICSR(1'b1)) dut5 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(x_in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .out_valid(x_out_valid), .out_ready(out_ready), .out_pc(x_out_pc),
    .out_rs1(x_out_rs1), .out_rs2(x_out_rs2), .out_rd(x_out_rd), .out_imm(x_out_imm),
    .out_alu_op(x_out_alu_op), .out_ctrl(x_out_ctrl), .out_funct3(x_out_funct3),
    .out_csr_op(x_out_csr_op), .out_csr_uimm(x_out_csr_uimm), .out_sys(x_out_sys),
    .out_illegal(x_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] inst;
    logic        ill;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [4:0]  alu;
    logic [9:0]  ctrl;
    logic [1:0]  csr;
    logic        uimm;
    logic [1:0]  sys;
    logic        x_ill;
    logic [4:0]  x_rd;
    logic [4:0]  x_alu;
  } vec_t;

  vec_t vt[$];
  int   n_vec;
  int   n_bad;

  function automatic vec_t mk(input logic [31:0] inst, input logic ill,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic [4:0] alu, input logic [9:0] ctrl,
                              input logic [1:0] csr, input logic uimm,
                              input logic [1:0] sys);
    vec_t v;
    v.inst = inst; v.ill = ill; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2;
    v.imm = imm; v.alu = alu; v.ctrl = ctrl; v.csr = csr; v.uimm = uimm;
    v.sys = sys; v.x_ill = ill; v.x_rd = rd; v.x_alu = alu;
    return v;
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, want %h", name, idx, act, exp);
    end
  endtask

  // Leaves both builds holding two entries with out_ready low.
  task automatic fill_two(input logic [31:0] pc0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093;
    in_pc     = pc0;
    @(posedge clk); @(negedge clk);
    in_inst   = 32'h00200093;
    in_pc     = pc0 + 32'd4;
    @(posedge clk); @(negedge clk);
    in_valid  = 1'b0;
    chk("fill_in_ready", 0, 32'(in_ready), 32'd0);
    chk("fill_out_pc", 0, out_pc, pc0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        v;
    logic [31:0] ti;
    logic [31:0] epc;

    n_vec = 0;
    n_bad = 0;

    // inst, ill, rd, rs1, rs2, imm, alu, ctrl, csr, uimm, sys
    vt.push_back(mk(32'h00500093, 0, 1, 0, 0, 32'd5,        5'd0,  10'h0C0, 0, 0, 0)); // addi x1,x0,5
    vt.push_back(mk(32'h002081B3, 0, 3, 1, 2, 32'd0,        5'd0,  10'h080, 0, 0, 0)); // add
    vt.push_back(mk(32'h402081B3, 0, 3, 1, 2, 32'd0,        5'd1,  10'h080, 0, 0, 0)); // sub
    vt.push_back(mk(32'h4020D1B3, 0, 3, 1, 2, 32'd0,        5'd7,  10'h080, 0, 0, 0)); // sra
    vt.push_back(mk(32'h4040D193, 0, 3, 1, 0, 32'd4,        5'd7,  10'h0C0, 0, 0, 0)); // srai
    vt.push_back(mk(32'h40409193, 1, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 0)); // slli bad funct7
    vt.push_back(mk(32'hFFF0B193, 0, 3, 1, 0, 32'hFFFFFFFF, 5'd4,  10'h0C0, 0, 0, 0)); // sltiu -1
    vt.push_back(mk(32'h123452B7, 0, 5, 0, 0, 32'h12345000, 5'd0,  10'h0C1, 0, 0, 0)); // lui
    vt.push_back(mk(32'h00001297, 0, 5, 0, 0, 32'h00001000, 5'd0,  10'h0C2, 0, 0, 0)); // auipc
    vt.push_back(mk(32'hFFDFF0EF, 0, 1, 0, 0, 32'hFFFFFFFC, 5'd0,  10'h088, 0, 0, 0)); // jal -4
    vt.push_back(mk(32'h00008067, 0, 0, 1, 0, 32'd0,        5'd0,  10'h0C4, 0, 0, 0)); // jalr
    vt.push_back(mk(32'h00208463, 0, 0, 1, 2, 32'd8,        5'd10, 10'h010, 0, 0, 0)); // beq +8
    vt.push_back(mk(32'h0020E463, 0, 0, 1, 2, 32'd8,        5'd14, 10'h010, 0, 0, 0)); // bltu +8
    vt.push_back(mk(32'h0020A463, 1, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 0)); // branch f3=010
    vt.push_back(mk(32'hFF812283, 0, 5, 2, 0, 32'hFFFFFFF8, 5'd0,  10'h2E0, 0, 0, 0)); // lw -8
    vt.push_back(mk(32'h00612623, 0, 0, 2, 6, 32'd12,       5'd0,  10'h140, 0, 0, 0)); // sw 12
    v = mk(32'h00000833, 1, 0, 0, 0, 32'd0, 5'd0, 10'h000, 0, 0, 0);                 // add x16
    v.x_ill = 1'b0; v.x_rd = 5'd16;
    vt.push_back(v);
    v = mk(32'h02208033, 1, 0, 0, 0, 32'd0, 5'd0, 10'h000, 0, 0, 0);                 // mul
    v.x_ill = 1'b0; v.x_alu = 5'd16;
    vt.push_back(v);
    vt.push_back(mk(32'h300312F3, 0, 5, 6, 0, 32'h300,      5'd0,  10'h080, 1, 0, 0)); // csrrw
    vt.push_back(mk(32'h300022F3, 0, 5, 0, 0, 32'h300,      5'd0,  10'h080, 0, 0, 0)); // csrrs x0 -> read
    vt.push_back(mk(32'h3001F2F3, 0, 5, 3, 0, 32'h300,      5'd0,  10'h080, 3, 1, 0)); // csrrci 3
    vt.push_back(mk(32'h00000073, 0, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 2)); // ecall
    vt.push_back(mk(32'h00100073, 0, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 1)); // ebreak
    vt.push_back(mk(32'h30200073, 1, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 0)); // mret
    vt.push_back(mk(32'h0000007F, 1, 0, 0, 0, 32'd0,        5'd0,  10'h000, 0, 0, 0)); // bad opcode

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_inst = '0; in_pc = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", 0, 32'(out_valid), 32'd0);
    chk("rst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("rst_out_pc", 0, out_pc, 32'd0);
    chk("rst_out_imm", 0, out_imm, 32'd0);
    chk("rst_out_ctrl", 0, 32'(out_ctrl), 32'd0);
    chk("rst_out_illegal", 0, 32'(out_illegal), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    out_ready = 1'b1;
    for (int i = 0; i < vt.size(); i++) begin
      epc      = 32'h1000 + (32'(i) << 2);
      in_valid = 1'b1;
      in_inst  = vt[i].inst;
      in_pc    = epc;
      @(posedge clk); @(negedge clk);
      ti = vt[i].inst;
      chk("valid", i, 32'(out_valid), 32'd1);
      chk("in_ready", i, 32'(in_ready), 32'd1);
      chk("pc", i, out_pc, epc);
      chk("illegal", i, 32'(out_illegal), 32'(vt[i].ill));
      chk("rd", i, 32'(out_rd), 32'(vt[i].rd));
      chk("rs1", i, 32'(out_rs1), 32'(vt[i].rs1));
      chk("rs2", i, 32'(out_rs2), 32'(vt[i].rs2));
      chk("imm", i, out_imm, vt[i].imm);
      chk("alu", i, 32'(out_alu_op), 32'(vt[i].alu));
      chk("ctrl", i, 32'(out_ctrl), 32'(vt[i].ctrl));
      chk("funct3", i, 32'(out_funct3), vt[i].ill ? 32'd0 : 32'(ti[14:12]));
      chk("csr_op", i, 32'(out_csr_op), 32'(vt[i].csr));
      chk("csr_uimm", i, 32'(out_csr_uimm), 32'(vt[i].uimm));
      chk("sys", i, 32'(out_sys), 32'(vt[i].sys));
      chk("x_illegal", i, 32'(x_out_illegal), 32'(vt[i].x_ill));
      chk("x_rd", i, 32'(x_out_rd), 32'(vt[i].x_rd));
      chk("x_alu", i, 32'(x_out_alu_op), 32'(vt[i].x_alu));
      chk("x_pc", i, x_out_pc, epc);
    end
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("drained_valid", 0, 32'(out_valid), 32'd0);

    // Stall with three back-to-back offers, then release.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_inst   = 32'h00100093; in_pc = 32'h2000;
    @(posedge clk); @(negedge clk);
    chk("stall_valid", 1, 32'(out_valid), 32'd1);
    chk("stall_in_ready", 1, 32'(in_ready), 32'd1);
    in_inst   = 32'h00200093; in_pc = 32'h2004;
    @(posedge clk); @(negedge clk);
    chk("stall_in_ready", 2, 32'(in_ready), 32'd0);
    chk("stall_pc", 2, out_pc, 32'h2000);
    in_inst   = 32'h00300093; in_pc = 32'h2008;
    @(posedge clk); @(negedge clk);
    chk("stall_in_ready", 3, 32'(in_ready), 32'd0);
    chk("stall_pc", 3, out_pc, 32'h2000);
    chk("stall_imm", 3, out_imm, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("order_pc", 1, out_pc, 32'h2004);
    chk("order_imm", 1, out_imm, 32'd2);
    chk("order_in_ready", 1, 32'(in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("order_pc", 2, out_pc, 32'h2008);
    chk("order_imm", 2, out_imm, 32'd3);
    chk("order_valid", 2, 32'(out_valid), 32'd1);
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("order_end_valid", 3, 32'(out_valid), 32'd0);

    // Flush with both entries full, a new offer and a drain in the same cycle.
    fill_two(32'h3000);
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_inst   = 32'h00400093;
    in_pc     = 32'h3100;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("flush_valid", 0, 32'(out_valid), 32'd0);
    chk("flush_in_ready", 0, 32'(in_ready), 32'd1);
    chk("x_flush_valid", 0, 32'(x_out_valid), 32'd0);
    flush    = 1'b0;
    in_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("flush_after_valid", 0, 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall.
    fill_two(32'h4000);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 0, 32'(out_valid), 32'd0);
    chk("arst_in_ready", 0, 32'(in_ready), 32'd1);
    chk("arst_pc", 0, out_pc, 32'd0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("arst_after_valid", 0, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("arst_after_valid", 1, 32'(out_valid), 32'd0);
    chk("arst_after_in_ready", 1, 32'(in_ready), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
